// File: rtl/pll_rst_seq_if.sv
// Lock-status and reset-sequencing signals between the PLL reset sequencer and its surroundings.
interface pll_rst_seq_if;
    logic       pll_lock;
    logic       pll_reset;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state_o;
    logic [7:0] relock_cnt;
    logic [7:0] timeout_cnt;

    modport slave (
        input  pll_lock,
        output pll_reset, sys_rst, ready, state_o, relock_cnt, timeout_cnt
    );

    modport master (
        output pll_lock,
        input  pll_reset, sys_rst, ready, state_o, relock_cnt, timeout_cnt
    );
endinterface

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases the
// system reset; re-sequences on lock loss or lock timeout and counts both events.
module pll_rst_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic         clk,
    input  logic         rst,
    pll_rst_seq_if.slave bus
);
    typedef enum logic [1:0] {
        PLLRST    = 2'b00,
        WAIT_LOCK = 2'b01,
        STABLE    = 2'b10,
        RUN       = 2'b11
    } state_t;

    localparam logic [20:0] RST_LAST     = 21'(PLL_RST_CYCLES - 1);
    localparam logic [20:0] STABLE_LAST  = 21'(LOCK_STABLE_CYCLES - 1);
    localparam logic [20:0] TIMEOUT_LAST = 21'(LOCK_TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [20:0] cnt_q;
    logic [1:0]  sync_q;
    logic        lock_s;
    logic [7:0]  relock_q, timeout_q;
    logic        relock_inc, timeout_inc;
    logic        pll_reset_q, sys_rst_q, ready_q;

    // pll_lock is asynchronous; only the second synchronizer stage feeds the FSM.
    assign lock_s = sync_q[1];

    always_comb begin
        state_d     = state_q;
        relock_inc  = 1'b0;
        timeout_inc = 1'b0;
        case (state_q)
            PLLRST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d     = PLLRST;
                    timeout_inc = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s)                    state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    relock_inc = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PLLRST;
            cnt_q       <= '0;
            sync_q      <= '0;
            relock_q    <= '0;
            timeout_q   <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.pll_lock};
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 21'd1;
            if (relock_inc && relock_q != 8'hFF)   relock_q  <= relock_q + 8'd1;
            if (timeout_inc && timeout_q != 8'hFF) timeout_q <= timeout_q + 8'd1;
            // Decodes are taken from the next state so they line up with state_q.
            pll_reset_q <= (state_d == PLLRST);
            sys_rst_q   <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign bus.pll_reset   = pll_reset_q;
    assign bus.sys_rst     = sys_rst_q;
    assign bus.ready       = ready_q;
    assign bus.state_o     = state_q;
    assign bus.relock_cnt  = relock_q;
    assign bus.timeout_cnt = timeout_q;
endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq: directed scenarios with fixed cycle expectations,
// then randomized lock activity compared against a behavioural model.
module tb_pll_rst_seq;
    localparam int P_RST = 4;
    localparam int P_STB = 8;
    localparam int P_TO  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    pll_rst_seq_if bus ();

    pll_rst_seq #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STB),
        .LOCK_TIMEOUT_CYCLES (P_TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase plus time spent in it, lock seen two cycles late.
    localparam int M_PLLRST = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3;
    int         m_state   = M_PLLRST;
    int         m_elapsed = 0;
    int         m_relock  = 0;
    int         m_timeout = 0;
    logic [1:0] m_hist    = 2'b00;

    always @(posedge clk) begin : model
        int   nxt, rel, tmo;
        logic seen;
        if (rst) begin
            m_state   <= M_PLLRST;
            m_elapsed <= 0;
            m_relock  <= 0;
            m_timeout <= 0;
            m_hist    <= 2'b00;
        end else begin
            seen = m_hist[1];
            nxt  = m_state;
            rel  = m_relock;
            tmo  = m_timeout;
            if (m_state == M_PLLRST) begin
                if (m_elapsed + 1 == P_RST) nxt = M_WAIT;
            end else if (m_state == M_WAIT) begin
                if (seen) nxt = M_STABLE;
                else if (m_elapsed + 1 == P_TO) begin
                    nxt = M_PLLRST;
                    tmo = (tmo < 255) ? tmo + 1 : 255;
                end
            end else if (m_state == M_STABLE) begin
                if (!seen) nxt = M_WAIT;
                else if (m_elapsed + 1 == P_STB) nxt = M_RUN;
            end else begin
                if (!seen) begin
                    nxt = M_WAIT;
                    rel = (rel < 255) ? rel + 1 : 255;
                end
            end
            m_hist    <= {m_hist[0], bus.pll_lock};
            m_elapsed <= (nxt == m_state) ? m_elapsed + 1 : 0;
            m_state   <= nxt;
            m_relock  <= rel;
            m_timeout <= tmo;
        end
    end

    // Leaves the bench at the negedge of cycle 0 (first cycle after reset release).
    task automatic do_reset(input logic lock);
        rst = 1'b1;
        bus.pll_lock = lock;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.state_o !== 2'b00) begin
            n_fail++; $display("FAIL reset_state: got %b expected 00", bus.state_o);
        end
        n_checks++;
        if (bus.pll_reset !== 1'b1) begin
            n_fail++; $display("FAIL reset_pll_reset: got %b expected 1", bus.pll_reset);
        end
        n_checks++;
        if (bus.sys_rst !== 1'b1) begin
            n_fail++; $display("FAIL reset_sys_rst: got %b expected 1", bus.sys_rst);
        end
        n_checks++;
        if (bus.ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.ready);
        end
        n_checks++;
        if (bus.relock_cnt !== 8'd0 || bus.timeout_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_counters: got relock=%0d timeout=%0d expected 0/0",
                               bus.relock_cnt, bus.timeout_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_lock_up;
        logic [1:0] exp_st;
        do_reset(1'b1);
        for (int c = 0; c < 15; c++) begin
            exp_st = (c < 4) ? 2'd0 : (c == 4) ? 2'd1 : (c < 13) ? 2'd2 : 2'd3;
            n_checks++;
            if (bus.state_o !== exp_st) begin
                n_fail++; $display("FAIL lockup_state c=%0d: got %0d expected %0d", c, bus.state_o, exp_st);
            end
            n_checks++;
            if (bus.pll_reset !== (exp_st == 2'd0) || bus.sys_rst !== (exp_st != 2'd3) ||
                bus.ready !== (exp_st == 2'd3)) begin
                n_fail++; $display("FAIL lockup_outputs c=%0d: got pll_reset=%b sys_rst=%b ready=%b expected state %0d decode",
                                   c, bus.pll_reset, bus.sys_rst, bus.ready, exp_st);
            end
            @(negedge clk);
        end
        $display("test_lock_up done");
    endtask

    task automatic test_timeout;
        do_reset(1'b0);
        for (int c = 0; c < 3 * (P_RST + P_TO) + 4; c++) begin
            n_checks++;
            if (bus.pll_reset !== ((c % (P_RST + P_TO)) < P_RST)) begin
                n_fail++; $display("FAIL timeout_pll_reset c=%0d: got %b expected %b", c, bus.pll_reset,
                                   ((c % (P_RST + P_TO)) < P_RST));
            end
            n_checks++;
            if (bus.timeout_cnt !== 8'(c / (P_RST + P_TO))) begin
                n_fail++; $display("FAIL timeout_cnt c=%0d: got %0d expected %0d", c, bus.timeout_cnt,
                                   c / (P_RST + P_TO));
            end
            n_checks++;
            if (bus.sys_rst !== 1'b1) begin
                n_fail++; $display("FAIL timeout_sys_rst c=%0d: got %b expected 1", c, bus.sys_rst);
            end
            @(negedge clk);
        end
        $display("test_timeout done");
    endtask

    task automatic test_lock_loss;
        int         first_hi;
        logic [1:0] exp_st;
        do_reset(1'b1);
        repeat (16) @(negedge clk);
        n_checks++;
        if (bus.state_o !== 2'd3) begin
            n_fail++; $display("FAIL loss_pre_run: got %0d expected 3", bus.state_o);
        end
        bus.pll_lock = 1'b0;
        first_hi = -1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (bus.sys_rst === 1'b1 && first_hi < 0) first_hi = k;
        end
        n_checks++;
        if (first_hi < 1 || first_hi > 3) begin
            n_fail++; $display("FAIL loss_sys_rst_latency: got %0d cycles expected 1..3", first_hi);
        end
        n_checks++;
        if (bus.relock_cnt !== 8'd1) begin
            n_fail++; $display("FAIL loss_relock_cnt: got %0d expected 1", bus.relock_cnt);
        end
        bus.pll_lock = 1'b1;
        for (int k = 4; k <= 14; k++) begin
            @(negedge clk);
            exp_st = (k <= 5) ? 2'd1 : (k <= 13) ? 2'd2 : 2'd3;
            n_checks++;
            if (bus.state_o !== exp_st) begin
                n_fail++; $display("FAIL loss_recover_state k=%0d: got %0d expected %0d", k, bus.state_o, exp_st);
            end
        end
        n_checks++;
        if (bus.ready !== 1'b1 || bus.sys_rst !== 1'b0) begin
            n_fail++; $display("FAIL loss_recover_ready: got ready=%b sys_rst=%b expected 1/0", bus.ready, bus.sys_rst);
        end
        $display("test_lock_loss done");
    endtask

    task automatic test_stable_glitch;
        logic [1:0] exp_st;
        do_reset(1'b1);
        for (int c = 0; c <= 20; c++) begin
            exp_st = (c < 4) ? 2'd0 : (c == 4) ? 2'd1 : (c <= 10) ? 2'd2 :
                     (c == 11) ? 2'd1 : (c <= 19) ? 2'd2 : 2'd3;
            n_checks++;
            if (bus.state_o !== exp_st) begin
                n_fail++; $display("FAIL glitch_state c=%0d: got %0d expected %0d", c, bus.state_o, exp_st);
            end
            bus.pll_lock = (c != 8);
            @(negedge clk);
        end
        n_checks++;
        if (bus.timeout_cnt !== 8'd0 || bus.relock_cnt !== 8'd0) begin
            n_fail++; $display("FAIL glitch_counters: got timeout=%0d relock=%0d expected 0/0",
                               bus.timeout_cnt, bus.relock_cnt);
        end
        $display("test_stable_glitch done");
    endtask

    task automatic test_rst_in_run;
        do_reset(1'b1);
        repeat (16) @(negedge clk);
        bus.pll_lock = 1'b0;
        @(negedge clk);
        bus.pll_lock = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (bus.state_o !== 2'd3 || bus.relock_cnt !== 8'd1) begin
            n_fail++; $display("FAIL rstrun_pre: got state=%0d relock=%0d expected 3/1", bus.state_o, bus.relock_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.state_o !== 2'd0 || bus.pll_reset !== 1'b1 || bus.sys_rst !== 1'b1 || bus.ready !== 1'b0) begin
            n_fail++; $display("FAIL rstrun_outputs: got state=%0d pll_reset=%b sys_rst=%b ready=%b expected 0/1/1/0",
                               bus.state_o, bus.pll_reset, bus.sys_rst, bus.ready);
        end
        n_checks++;
        if (bus.relock_cnt !== 8'd0) begin
            n_fail++; $display("FAIL rstrun_relock: got %0d expected 0", bus.relock_cnt);
        end
        $display("test_rst_in_run done");
    endtask

    task automatic test_saturation;
        int exp_rel;
        do_reset(1'b1);
        repeat (16) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            bus.pll_lock = 1'b0;
            @(negedge clk);
            bus.pll_lock = 1'b1;
            repeat (16) @(negedge clk);
            exp_rel = (i + 1 < 255) ? i + 1 : 255;
            n_checks++;
            if (bus.state_o !== 2'd3 || bus.relock_cnt !== 8'(exp_rel)) begin
                n_fail++; $display("FAIL sat_relock i=%0d: got state=%0d relock=%0d expected 3/%0d",
                                   i, bus.state_o, bus.relock_cnt, exp_rel);
            end
        end
        $display("test_saturation done relock_cnt=%0d", bus.relock_cnt);
    endtask

    task automatic test_random;
        int   run_left;
        logic lock_val;
        do_reset(1'b0);
        run_left = 0;
        lock_val = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            n_checks++;
            if (bus.state_o !== 2'(m_state)) begin
                n_fail++; $display("FAIL rand_state c=%0d: got %0d expected %0d", c, bus.state_o, m_state);
            end
            n_checks++;
            if (bus.pll_reset !== (m_state == M_PLLRST) || bus.sys_rst !== (m_state != M_RUN) ||
                bus.ready !== (m_state == M_RUN)) begin
                n_fail++; $display("FAIL rand_decode c=%0d: got pll_reset=%b sys_rst=%b ready=%b expected state %0d decode",
                                   c, bus.pll_reset, bus.sys_rst, bus.ready, m_state);
            end
            n_checks++;
            if (bus.relock_cnt !== 8'(m_relock) || bus.timeout_cnt !== 8'(m_timeout)) begin
                n_fail++; $display("FAIL rand_counters c=%0d: got relock=%0d timeout=%0d expected %0d/%0d",
                                   c, bus.relock_cnt, bus.timeout_cnt, m_relock, m_timeout);
            end
            if (run_left == 0) begin
                lock_val = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 3) == 0) run_left = 1;
                else run_left = lock_val ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 45));
            end
            run_left--;
            bus.pll_lock = lock_val;
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        $display("test_random done relock=%0d timeout=%0d", m_relock, m_timeout);
    endtask

    initial begin
        rst = 1'b1;
        bus.pll_lock = 1'b0;
        test_reset();
        test_lock_up();
        test_timeout();
        test_lock_loss();
        test_stable_glitch();
        test_rst_in_run();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before 2000000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 The block SHALL have parameter PLL_RST_CYCLES, default 16, giving the number of cycles the PLL reset request is held asserted (legal range 1..2^20).
REQ-002 The block SHALL have parameter LOCK_STABLE_CYCLES, default 1024, giving the number of consecutive locked cycles required before the system reset is released (legal range 1..2^20).
REQ-003 The block SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536, giving the maximum wait for lock before the PLL is reset again (legal range 2..2^20).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, driven by a free-running source (not a PLL output).
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port pll_lock, input, 1 bit: the PLL lock indicator, asynchronous to clk.
REQ-007 The block SHALL have port pll_reset, output, 1 bit: drives the PLL RESET pin; high means reset.
REQ-008 The block SHALL have port sys_rst, output, 1 bit: synchronous active-high reset for logic clocked from the PLL outputs.
REQ-009 The block SHALL have port ready, output, 1 bit: high when the PLL is locked and stable.
REQ-010 The block SHALL have port state_o, output, 2 bits: current state (00 PLLRST, 01 WAIT_LOCK, 10 STABLE, 11 RUN).
REQ-011 The block SHALL have port relock_cnt, output, 8 bits: the number of RUN-state lock losses, saturating.
REQ-012 The block SHALL have port timeout_cnt, output, 8 bits: the number of lock timeouts, saturating.

Function
REQ-013 pll_lock SHALL pass through a 2-flop synchronizer to give lock_s, with a latency of 2 clk cycles; no other logic SHALL sample pll_lock directly.
REQ-014 A single cycle counter cnt, 21 bits wide, SHALL clear to 0 on every state entry and increment by 1 each cycle while the state is held.
REQ-015 In PLLRST, pll_reset SHALL be 1; when cnt==PLL_RST_CYCLES-1 the next state SHALL be WAIT_LOCK, so PLLRST lasts exactly PLL_RST_CYCLES cycles.
REQ-016 In WAIT_LOCK, if lock_s==1 the next state SHALL be STABLE.
REQ-017 In WAIT_LOCK, otherwise, if cnt==LOCK_TIMEOUT_CYCLES-1 the next state SHALL be PLLRST and timeout_cnt SHALL increment.
REQ-018 In STABLE, lock_s==0 SHALL send the next state to WAIT_LOCK, which restarts the timeout window.
REQ-019 In STABLE, if lock_s==1 and cnt==LOCK_STABLE_CYCLES-1 the next state SHALL be RUN, so a glitch-free STABLE lasts exactly LOCK_STABLE_CYCLES cycles.
REQ-020 In RUN, lock_s==0 SHALL send the next state to WAIT_LOCK and increment relock_cnt; RUN SHALL have no other exit except rst.
REQ-021 Outputs SHALL be Moore decodes of the state register: pll_reset=(state==PLLRST), sys_rst=(state!=RUN), ready=(state==RUN), state_o=state; no combinational path SHALL run from pll_lock to any output.
REQ-022 relock_cnt and timeout_cnt SHALL saturate at 255 and never wrap; they SHALL clear only on rst.
REQ-023 When a lock loss in RUN occurs, sys_rst SHALL be 1 no later than 3 clk cycles after pll_lock falls, counting 2 synchronizer cycles and 1 state-register cycle.
REQ-024 A lock_s pulse of 1 cycle during WAIT_LOCK SHALL still enter STABLE; the immediate drop that follows SHALL return the state to WAIT_LOCK with a fresh timeout window.
REQ-025 A pll_lock glitch shorter than 1 clk cycle MAY be missed by the synchronizer; no behaviour SHALL depend on catching it.

Reset
REQ-026 While rst==1, the block SHALL force state=PLLRST, cnt=0, relock_cnt=0, timeout_cnt=0, and both synchronizer flops to 0; the outputs SHALL then read pll_reset=1, sys_rst=1, ready=0, state_o=00.
REQ-027 rst asserted in any state, including mid-count, SHALL take effect on the next clk edge, and the full sequence SHALL restart from PLLRST on the cycle after rst falls.

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32)
REQ-028 Case: pll_lock held at 1, then rst released at cycle 0 -> pll_reset=1 for cycles 0-3, WAIT_LOCK at cycle 4, STABLE at cycle 5, and at cycle 13 RUN with sys_rst=0 and ready=1.
REQ-029 Case: pll_lock held at 0 -> pll_reset pulses high for 4 cycles every 36 cycles, and timeout_cnt reads 1, 2, 3 after successive timeouts; sys_rst stays 1.
REQ-030 Case: in RUN, pll_lock drops for 3 cycles -> sys_rst=1 within 3 cycles and relock_cnt=1; after lock returns, STABLE for 8 cycles, then RUN.
REQ-031 Case: in STABLE at cnt=5, lock_s is low for 1 cycle -> the state returns to WAIT_LOCK and a full 8-cycle STABLE is required afterwards; timeout_cnt is unchanged.
REQ-032 Case: rst pulsed for 1 cycle while in RUN -> the next cycle reads state_o=00, pll_reset=1, sys_rst=1, and relock_cnt=0.
REQ-033 Case: 300 RUN lock losses -> relock_cnt reads 255 and holds at 255.
